// File: rtl/slc3_pkg.sv
// Shared types and constants for the SLC-3 datapath: mux encodings, ALU ops,
// memory-engine states and reset values.
package slc3_pkg;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_AND  = 2'b01,
        ALU_NOT  = 2'b10,
        ALU_PASS = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_INC  = 2'b00,
        PC_BUS  = 2'b01,
        PC_ADDR = 2'b10,
        PC_HOLD = 2'b11
    } pcmux_e;

    typedef enum logic [1:0] {
        A2_ZERO  = 2'b00,
        A2_OFF6  = 2'b01,
        A2_OFF9  = 2'b10,
        A2_OFF11 = 2'b11
    } addr2mux_e;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'b00,
        MEM_WAIT = 2'b01,
        MEM_DONE = 2'b10
    } mem_state_e;

    localparam logic [2:0] NZP_RESET = 3'b010;
    localparam logic [2:0] R7        = 3'd7;
    localparam int         REG_COUNT = 8;

endpackage

// File: rtl/slc3_datapath_gen_if.sv
// Memory-access handshake between the datapath (master) and the control FSM /
// memory subsystem (slave).
interface slc3_datapath_gen_if #(
    parameter int DATA_W = 16
);
    logic              mem_start;
    logic              mem_we;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_req;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_done;
    logic              mem_err;

    modport master (
        input  mem_start, mem_we, mem_ready, mem_rdata,
        output mem_req, mem_wr, mem_addr, mem_wdata, mem_done, mem_err
    );

    modport slave (
        output mem_start, mem_we, mem_ready, mem_rdata,
        input  mem_req, mem_wr, mem_addr, mem_wdata, mem_done, mem_err
    );
endinterface

// File: rtl/slc3_regfile.sv
// 8-entry general register file: two combinational read ports, one write port.
// Writes land on the clock edge, so a same-cycle read still sees the old value.
module slc3_regfile
    import slc3_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        raddr_a,
    input  logic [2:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [REG_COUNT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/slc3_datapath_gen.sv
// SLC-3 datapath: PC/IR/MAR/MDR, register file, ALU, address adder, NZP/BEN on a
// single gated bus, plus a handshaked memory engine with timeout and bus-conflict guard.
module slc3_datapath_gen
    import slc3_pkg::*;
#(
    parameter int                DATA_W      = 16,
    parameter logic [DATA_W-1:0] RESET_PC    = '0,
    parameter int                MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gate_pc,
    input  logic              gate_mdr,
    input  logic              gate_alu,
    input  logic              gate_marmux,
    input  logic              ld_pc,
    input  logic              ld_ir,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic              ld_reg,
    input  logic              ld_cc,
    input  logic              ld_ben,
    input  logic [1:0]        pcmux,
    input  logic              drmux,
    input  logic              sr1mux,
    input  logic              addr1mux,
    input  logic [1:0]        addr2mux,
    input  logic [1:0]        aluk,
    slc3_datapath_gen_if.master mem,
    output logic              bus_conflict,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] mar,
    output logic [DATA_W-1:0] mdr,
    output logic              ben,
    output logic [2:0]        nzp
);

    localparam int         CNT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam logic [1:0] S_IDLE = MEM_IDLE;
    localparam logic [1:0] S_WAIT = MEM_WAIT;
    localparam logic [1:0] S_DONE = MEM_DONE;

    function automatic logic signed [DATA_W-1:0] sext5(input logic [4:0] f);
        return DATA_W'($signed(f));
    endfunction

    function automatic logic signed [DATA_W-1:0] sext6(input logic [5:0] f);
        return DATA_W'($signed(f));
    endfunction

    function automatic logic signed [DATA_W-1:0] sext9(input logic [8:0] f);
        return DATA_W'($signed(f));
    endfunction

    function automatic logic signed [DATA_W-1:0] sext11(input logic [10:0] f);
        return DATA_W'($signed(f));
    endfunction

    function automatic logic [2:0] cc_of(input logic [DATA_W-1:0] v);
        if (v[DATA_W-1]) begin
            return 3'b100;
        end else if (v == '0) begin
            return 3'b010;
        end else begin
            return 3'b001;
        end
    endfunction

    logic [1:0]        state;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              mem_wr_q;
    logic              mem_err_q;
    logic [2:0]        n_gates;
    logic              bus_ok;
    logic [DATA_W-1:0] bus;
    logic [2:0]        sr1_idx;
    logic [2:0]        dr_idx;
    logic [DATA_W-1:0] sr1_val;
    logic [DATA_W-1:0] sr2_val;
    logic [DATA_W-1:0] sr2_op;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] addr1;
    logic [DATA_W-1:0] addr2;
    logic [DATA_W-1:0] addr_sum;
    logic [DATA_W-1:0] pc_next;
    logic              pc_load;
    logic              mem_read_hit;

    assign sr1_idx = sr1mux ? ir[8:6] : ir[11:9];
    assign dr_idx  = drmux ? R7 : ir[11:9];

    slc3_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (ld_reg && bus_ok),
        .waddr   (dr_idx),
        .wdata   (bus),
        .raddr_a (sr1_idx),
        .raddr_b (ir[2:0]),
        .rdata_a (sr1_val),
        .rdata_b (sr2_val)
    );

    assign sr2_op = ir[5] ? sext5(ir[4:0]) : sr2_val;

    always_comb begin
        alu_out = '0;
        case (alu_op_e'(aluk))
            ALU_ADD:  alu_out = sr1_val + sr2_op;
            ALU_AND:  alu_out = sr1_val & sr2_op;
            ALU_NOT:  alu_out = ~sr1_val;
            ALU_PASS: alu_out = sr1_val;
            default:  alu_out = '0;
        endcase
    end

    assign addr1 = addr1mux ? sr1_val : pc;

    always_comb begin
        addr2 = '0;
        case (addr2mux_e'(addr2mux))
            A2_ZERO:  addr2 = '0;
            A2_OFF6:  addr2 = sext6(ir[5:0]);
            A2_OFF9:  addr2 = sext9(ir[8:0]);
            A2_OFF11: addr2 = sext11(ir[10:0]);
            default:  addr2 = '0;
        endcase
    end

    assign addr_sum = addr1 + addr2;

    // Gates are meant to be one-hot; on overlap the bus reads 0 and every bus-fed load is blocked.
    assign n_gates      = 3'(gate_pc) + 3'(gate_mdr) + 3'(gate_alu) + 3'(gate_marmux);
    assign bus_conflict = (n_gates > 3'd1);
    assign bus_ok       = !bus_conflict;

    always_comb begin
        bus = '0;
        if (bus_ok) begin
            if (gate_pc)     bus = pc;
            if (gate_mdr)    bus = mdr;
            if (gate_alu)    bus = alu_out;
            if (gate_marmux) bus = addr_sum;
        end
    end

    always_comb begin
        pc_next = pc;
        case (pcmux_e'(pcmux))
            PC_INC:  pc_next = pc + DATA_W'(1);
            PC_BUS:  pc_next = bus;
            PC_ADDR: pc_next = addr_sum;
            PC_HOLD: pc_next = pc;
            default: pc_next = pc;
        endcase
    end

    assign pc_load      = ld_pc && !(pcmux_e'(pcmux) == PC_BUS && bus_conflict);
    assign mem_read_hit = (state == S_WAIT) && mem.mem_ready && !mem_wr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc  <= RESET_PC;
            ir  <= '0;
            mar <= '0;
            mdr <= '0;
            nzp <= NZP_RESET;
            ben <= 1'b0;
        end else begin
            if (pc_load)                 pc  <= pc_next;
            if (ld_ir && bus_ok)         ir  <= bus;
            if (ld_mar && bus_ok)        mar <= bus;
            if (ld_cc && bus_ok)         nzp <= cc_of(bus);
            // ben samples the pre-update nzp when ld_cc fires in the same cycle.
            if (ld_ben)                  ben <= |(ir[11:9] & nzp);
            // While an access is in flight the memory engine owns MDR.
            if (mem_read_hit) begin
                mdr <= mem.mem_rdata;
            end else if (ld_mdr && bus_ok && state != S_WAIT) begin
                mdr <= bus;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            tmo_cnt   <= '0;
            mem_wr_q  <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem.mem_start) begin
                        state    <= S_WAIT;
                        mem_wr_q <= mem.mem_we;
                        tmo_cnt  <= '0;
                    end
                end
                S_WAIT: begin
                    if (mem.mem_ready) begin
                        state <= S_DONE;
                    end else if (tmo_cnt == CNT_W'(MEM_TIMEOUT)) begin
                        state     <= S_DONE;
                        mem_err_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem.mem_req   = (state == S_WAIT);
    assign mem.mem_done  = (state == S_DONE);
    assign mem.mem_wr    = mem_wr_q;
    assign mem.mem_err   = mem_err_q;
    assign mem.mem_addr  = mar;
    assign mem.mem_wdata = mdr;

endmodule
